// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state type and one-hot helper
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority scan of four requests starting at index start
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       valid,
  output logic [1:0] idx
);
  // Descending scan so the lowest rotated offset is written last and wins
  always_comb begin
    valid = |req;
    idx = start;
    for (int k = 3; k >= 0; k--) if (req[start + 2'(k)]) idx = start + 2'(k);
  end
endmodule

// File: rtl/rr_arb_4to1.sv
// rr_arb_4to1: round-robin 4-way arbiter with beat-limited grant hold driving a 4:1 mux
module rr_arb_4to1 import arb_pkg::*; #(
  parameter int MAX_HOLD = 4,
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             en,
  output logic [CNT_W-1:0] beat_cnt
);
  arb_state_t state, state_nxt;
  logic [1:0] ptr, ptr_nxt, sel_nxt, idx;
  logic [3:0] gnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic en_nxt, valid, rel, load;
  rr_pick4 u_pick (
    .req   (req),
    .start ((state == GRANT ? sel : ptr) + 2'd1),
    .valid (valid),
    .idx   (idx)
  );
  assign rel = state == GRANT && (!req[sel] || (ready && beat_cnt == CNT_W'(MAX_HOLD - 1)));
  assign load = (state == IDLE || rel) && valid;
  always_comb begin
    state_nxt = state;
    ptr_nxt = rel ? sel : ptr;
    sel_nxt = sel;
    gnt_nxt = gnt;
    en_nxt = en;
    cnt_nxt = beat_cnt;
    if (load) begin
      state_nxt = GRANT;
      sel_nxt = idx;
      gnt_nxt = onehot4(idx);
      en_nxt = 1'b1;
      cnt_nxt = '0;
    end else if (rel || state != GRANT) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      en_nxt = 1'b0;
      cnt_nxt = '0;
    end else if (ready) begin
      cnt_nxt = beat_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd3;
      sel <= 2'd0;
      gnt <= '0;
      en <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      sel <= sel_nxt;
      gnt <= gnt_nxt;
      en <= en_nxt;
      beat_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arb_4to1.sv
// tb_rr_arb_4to1: directed scenarios plus random traffic against a behavioural arbiter model
module tb_rr_arb_4to1;
  localparam int MH = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic en;
  logic [CW-1:0] beat_cnt;
  int checks = 0;
  int failures = 0;
  int m_owner, m_cnt, m_ptr, m_sel;

  rr_arb_4to1 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .gnt(gnt), .sel(sel), .en(en), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 3; m_sel = 0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = pick(m_ptr, req); m_sel = m_owner; m_cnt = 0;
      end
    end else if (!req[m_owner] || (ready && m_cnt == MH - 1)) begin
      m_ptr = m_owner;
      m_cnt = 0;
      if (req != 0) begin
        m_owner = pick(m_owner, req); m_sel = m_owner;
      end else m_owner = -1;
    end else if (ready) m_cnt++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"}, gnt, m_owner < 0 ? 0 : (1 << m_owner));
    chk({tag, ".en"}, en, m_owner >= 0);
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".cnt"}, beat_cnt, m_cnt);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    model_reset();
    #2 check_model("por");
    @(negedge clk) rst = 1'b0;
    req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc("fair");
    req = 4'b0000;
    cyc("idle0");
    req = 4'b0010;
    cyc("drop_g");
    cyc("drop_b1");
    cyc("drop_b2");
    chk("drop_cnt2", beat_cnt, 2);
    req = 4'b0101;
    cyc("drop");
    chk("drop_gnt", gnt, 4'b0100);
    req = 4'b0000;
    cyc("idle");
    chk("idle_sel", sel, 2);
    req = 4'b0001; ready = 1'b0;
    for (int i = 0; i < 11; i++) cyc("stall");
    chk("stall_cnt", beat_cnt, 0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc("stall_go");
    req = 4'b0100;
    for (int i = 0; i < 12; i++) cyc("sole");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk) rst = 1'b0;
    req = 4'b1000;
    cyc("post_rst");
    chk("post_rst_sel", sel, 3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
